// File: rtl/instr_fetch_unit.sv
// Loadable 16-entry instruction store with a stallable PC sequencer feeding a registered IR.
// Define IFU_WRAP_EN to loop the program forever instead of halting after the last word.
module instr_fetch_unit #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned IW    = 12,
  parameter int unsigned AW    = 4
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          load_valid,
  input  logic [IW-1:0] load_data,
  input  logic          load_last,
  output logic          load_ready,
  input  logic          run,
  input  logic          stall,
  output logic [IW-1:0] ir,
  output logic          ir_valid,
  output logic [AW-1:0] pc,
  output logic [AW:0]   count,
  output logic          halted
);

  typedef enum logic [1:0] {StIdle, StLoaded, StRun, StHalt} state_e;

  localparam logic [AW:0] FullCnt = (AW+1)'(DEPTH);

  state_e        state_q, state_d;
  logic [IW-1:0] ir_q, ir_d;
  logic          ir_valid_q, ir_valid_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW:0]   count_q, count_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic          halted_q, halted_d;
  logic          mem_we;
  logic          last_issue;

  logic [IW-1:0] mem [DEPTH];

  // The issued address is the final loaded word.
  assign last_issue = ({1'b0, pc_q} == (count_q - 1'b1));

  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    pc_d       = pc_q;
    count_d    = count_q;
    wptr_d     = wptr_q;
    halted_d   = halted_q;
    mem_we     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (load_valid) begin
          mem_we  = 1'b1;
          wptr_d  = wptr_q + 1'b1;
          count_d = count_q + 1'b1;
          if (load_last || (count_d == FullCnt)) begin
            state_d = StLoaded;
          end
        end
      end
      StLoaded: begin
        if (run) begin
          state_d = StRun;
          pc_d    = '0;
        end
      end
      StRun: begin
        if (!stall) begin
          ir_d       = mem[pc_q];
          ir_valid_d = 1'b1;
          pc_d       = pc_q + 1'b1;
          if (last_issue) begin
            pc_d = '0;
`ifdef IFU_WRAP_EN
            state_d = StRun;
`else
            state_d = StHalt;
`endif
          end
        end
      end
      StHalt: begin
        // halted is registered here so it rises on the edge ir_valid falls.
        ir_valid_d = 1'b0;
        halted_d   = 1'b1;
        if (run) begin
          state_d  = StRun;
          pc_d     = '0;
          halted_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
      pc_q       <= '0;
      count_q    <= '0;
      wptr_q     <= '0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      pc_q       <= pc_d;
      count_q    <= count_d;
      wptr_q     <= wptr_d;
      halted_q   <= halted_d;
    end
  end

  // Store contents are deliberately not reset.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[wptr_q] <= load_data;
    end
  end

  assign load_ready = (state_q == StIdle);
  assign ir         = ir_q;
  assign ir_valid   = ir_valid_q;
  assign pc         = pc_q;
  assign count      = count_q;
  assign halted     = halted_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit; covers the IFU_WRAP_EN build when defined.
module tb_instr_fetch_unit;

  logic        clock;
  logic        resetn;
  logic        load_valid;
  logic [11:0] load_data;
  logic        load_last;
  logic        load_ready;
  logic        run;
  logic        stall;
  logic [11:0] ir;
  logic        ir_valid;
  logic [3:0]  pc;
  logic [4:0]  count;
  logic        halted;

  int n_tests = 0;
  int n_fail  = 0;

  instr_fetch_unit #(
    .DEPTH(16),
    .IW   (12),
    .AW   (4)
  ) dut (
    .clock     (clock),
    .resetn    (resetn),
    .load_valid(load_valid),
    .load_data (load_data),
    .load_last (load_last),
    .load_ready(load_ready),
    .run       (run),
    .stall     (stall),
    .ir        (ir),
    .ir_valid  (ir_valid),
    .pc        (pc),
    .count     (count),
    .halted    (halted)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " load_ready"}, 32'(load_ready), 32'd1);
    chk({tag, " ir"},         32'(ir),         32'd0);
    chk({tag, " ir_valid"},   32'(ir_valid),   32'd0);
    chk({tag, " pc"},         32'(pc),         32'd0);
    chk({tag, " count"},      32'(count),      32'd0);
    chk({tag, " halted"},     32'(halted),     32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [11:0] prog [3];
    prog[0] = 12'h943;
    prog[1] = 12'h982;
    prog[2] = 12'h9C5;
    resetn = 1'b0; load_valid = 1'b0; load_data = '0; load_last = 1'b0;
    run = 1'b0; stall = 1'b0;
    #12;
    chk_reset("rst");
    resetn = 1'b1;
    step();

    // Three-word load; run coinciding with the first word must be ignored.
    load_valid = 1'b1; load_data = prog[0]; run = 1'b1;
    step();
    chk("ld1 count", 32'(count), 32'd1);
    chk("ld1 ready", 32'(load_ready), 32'd1);
    chk("ld1 no fetch", 32'(ir_valid), 32'd0);
    load_data = prog[1]; run = 1'b0;
    step();
    chk("ld2 count", 32'(count), 32'd2);
    chk("ld2 no fetch", 32'(ir_valid), 32'd0);
    load_data = prog[2]; load_last = 1'b1;
    step();
    chk("ld3 count", 32'(count), 32'd3);
    chk("ld3 ready low", 32'(load_ready), 32'd0);
    load_data = 12'hFFF; load_last = 1'b0;
    step();
    chk("ld extra ignored", 32'(count), 32'd3);
    load_valid = 1'b0; run = 1'b1;
    step();
    run = 1'b0;
    chk("run edge valid", 32'(ir_valid), 32'd0);
    chk("run edge pc", 32'(pc), 32'd0);

`ifdef IFU_WRAP_EN
    for (int i = 0; i < 12; i++) begin
      step();
      chk("wrap ir", 32'(ir), 32'(prog[i % 3]));
      chk("wrap valid", 32'(ir_valid), 32'd1);
      chk("wrap halted", 32'(halted), 32'd0);
      chk("wrap pc", 32'(pc), 32'((i + 1) % 3));
    end
`else
    for (int i = 0; i < 3; i++) begin
      step();
      chk("seq ir", 32'(ir), 32'(prog[i]));
      chk("seq valid", 32'(ir_valid), 32'd1);
      chk("seq halted", 32'(halted), 32'd0);
      chk("seq pc", 32'(pc), 32'((i + 1) % 3));
    end
    step();
    chk("halt halted", 32'(halted), 32'd1);
    chk("halt valid", 32'(ir_valid), 32'd0);
    chk("halt ir kept", 32'(ir), 32'h9C5);
    chk("halt count", 32'(count), 32'd3);
    step();
    chk("halt stays", 32'(halted), 32'd1);

    // Restart from HALT with a two-cycle stall while ir=0x982.
    run = 1'b1;
    step();
    run = 1'b0;
    chk("rerun halted", 32'(halted), 32'd0);
    chk("rerun valid", 32'(ir_valid), 32'd0);
    step();
    chk("rerun ir0", 32'(ir), 32'h943);
    step();
    chk("rerun ir1", 32'(ir), 32'h982);
    chk("rerun pc1", 32'(pc), 32'd2);
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("stall ir", 32'(ir), 32'h982);
      chk("stall pc", 32'(pc), 32'd2);
      chk("stall valid", 32'(ir_valid), 32'd1);
    end
    stall = 1'b0;
    step();
    chk("resume ir", 32'(ir), 32'h9C5);
    chk("resume halted", 32'(halted), 32'd0);
    step();
    chk("stall halt", 32'(halted), 32'd1);
    chk("stall halt valid", 32'(ir_valid), 32'd0);

    // Asynchronous reset mid-run at pc=2.
    run = 1'b1;
    step();
    run = 1'b0;
    step();
    step();
    chk("pre-rst pc", 32'(pc), 32'd2);
    #2 resetn = 1'b0;
    #1;
    chk_reset("async rst");
    #3 resetn = 1'b1;

    // Sixteen words without load_last; a 17th word must not land in mem[0].
    load_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      load_data = 12'h100 + 12'(i);
      step();
    end
    chk("full count", 32'(count), 32'd16);
    chk("full ready low", 32'(load_ready), 32'd0);
    load_data = 12'hABC;
    step();
    chk("word17 count", 32'(count), 32'd16);
    load_valid = 1'b0; run = 1'b1;
    step();
    run = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step();
      chk("full ir", 32'(ir), 32'(12'h100 + 12'(i)));
      chk("full pc", 32'(pc), 32'((i + 1) % 16));
    end
    step();
    chk("full halted", 32'(halted), 32'd1);
    chk("full halt pc", 32'(pc), 32'd0);
    chk("full halt valid", 32'(ir_valid), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
